// File: rtl/next_hop_lookup.sv
// next_hop_lookup
// ----------------
// Lookup engine that is the only master of the next-hop RAM port. A lookup
// reads the two-word entry at word addresses {idx,0} and {idx,1} and returns
// the destination MAC, the output-port bitmap and the hit flag on a
// valid/ready response channel. Host table-update writes share the same RAM
// port and are arbitrated in IDLE. When both sides are waiting, the arbiter
// alternates between them so that neither can starve the other.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   req_valid/req_ready          lookup request handshake (req_ready is combinational)
//   req_idx, req_tag             entry index 0..1023, opaque tag
//   rsp_valid/rsp_ready          response handshake
//   rsp_tag, rsp_mac,
//   rsp_port, rsp_hit            response fields, held stable while stalled
//   wr_req/wr_ack                host write; wr_req is held until the wr_ack pulse
//   wr_addr, wr_data, wr_be      host word address, data, byte enables
//   ram_addr, ram_en, ram_we,
//   ram_wdata, ram_rdata         RAM port (1-cycle synchronous read)
//
// Entry layout: W0 = MAC[47:16]; W1[31:16] = MAC[15:0], W1[15:8] = port,
// W1[0] = valid.
module next_hop_lookup #(
    parameter int         TAG_W     = 8,
    parameter logic [7:0] MISS_PORT = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [9:0]       req_idx,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [47:0]      rsp_mac,
    output logic [7:0]       rsp_port,
    output logic             rsp_hit,
    input  logic             wr_req,
    input  logic [10:0]      wr_addr,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_be,
    output logic             wr_ack,
    output logic [10:0]      ram_addr,
    output logic             ram_en,
    output logic [3:0]       ram_we,
    output logic [31:0]      ram_wdata,
    input  logic [31:0]      ram_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        CAP  = 3'd2,
        RESP = 3'd3,
        WACK = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_prio_lookup;  // 1: lookup wins the next tie
    logic [9:0]       r_idx;
    logic [TAG_W-1:0] r_tag;
    logic [31:0]      r_w0;           // MAC[47:16] captured in RD1
    logic             w_sel_wr;
    logic             w_sel_rd;
    logic [6:0]       w_unused_w1;    // W1 reserved bits, intentionally dropped

    assign w_unused_w1 = ram_rdata[7:1];

    // Single-cycle arbitration in IDLE. Gated by reset so that nothing is
    // accepted or written while the block is being reset.
    always_comb begin
        w_sel_wr = 1'b0;
        w_sel_rd = 1'b0;
        if (!reset && r_state == IDLE) begin
            w_sel_wr = wr_req && (!req_valid || !r_prio_lookup);
            w_sel_rd = req_valid && !w_sel_wr;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_sel_wr) begin
                    w_state_next = WACK;
                end else if (w_sel_rd) begin
                    w_state_next = RD1;
                end
            end
            RD1:  w_state_next = CAP;
            CAP:  w_state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            WACK:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output logic for the RAM port and handshakes. The write cycle never
    // asserts ram_en, and reads never assert ram_we.
    always_comb begin
        req_ready = w_sel_rd;
        wr_ack    = !reset && (r_state == WACK);
        ram_addr  = 11'd0;
        ram_en    = 1'b0;
        ram_we    = 4'd0;
        ram_wdata = 32'd0;
        if (w_sel_wr) begin
            ram_addr  = wr_addr;
            ram_we    = wr_be;
            ram_wdata = wr_data;
        end else if (w_sel_rd) begin
            ram_addr = {req_idx, 1'b0};
            ram_en   = 1'b1;
        end else if (!reset && r_state == RD1) begin
            ram_addr = {r_idx, 1'b1};
            ram_en   = 1'b1;
        end
    end

    // Datapath and registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio_lookup <= 1'b0;
            r_idx         <= 10'd0;
            r_tag         <= '0;
            r_w0          <= 32'd0;
            rsp_valid     <= 1'b0;
            rsp_tag       <= '0;
            rsp_mac       <= 48'd0;
            rsp_port      <= 8'd0;
            rsp_hit       <= 1'b0;
        end else begin
            if (w_sel_wr) begin
                r_prio_lookup <= 1'b1;
            end
            if (w_sel_rd) begin
                r_prio_lookup <= 1'b0;
                r_idx         <= req_idx;
                r_tag         <= req_tag;
            end
            if (r_state == RD1) begin
                r_w0 <= ram_rdata;
            end
            if (r_state == CAP) begin
                rsp_valid <= 1'b1;
                rsp_tag   <= r_tag;
                rsp_mac   <= {r_w0, ram_rdata[31:16]};
                rsp_hit   <= ram_rdata[0];
                rsp_port  <= ram_rdata[0] ? ram_rdata[15:8] : MISS_PORT;
            end
            if (r_state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_next_hop_lookup.sv
// Testbench for next_hop_lookup: directed stimulus with a behavioural RAM,
// expected responses queued at request acceptance and checked by a monitor.
module tb_next_hop_lookup;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_idx;
    logic [7:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_tag;
    logic [47:0] rsp_mac;
    logic [7:0]  rsp_port;
    logic        rsp_hit;
    logic        wr_req;
    logic [10:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        wr_ack;
    logic [10:0] ram_addr;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    always #5 clk = ~clk;

    next_hop_lookup #(.TAG_W(8), .MISS_PORT(8'h00)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_mac(rsp_mac),
        .rsp_port(rsp_port), .rsp_hit(rsp_hit),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_ack(wr_ack),
        .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 2048 x 32 RAM with byte enables and registered read
    logic [31:0] mem [0:2047];
    logic        mem_clear = 1'b1;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 32'd0;
        end else begin
            if (ram_en) ram_rdata <= mem[ram_addr];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic [7:0]  tag;
        logic [47:0] mac;
        logic [7:0]  port;
        logic        hit;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic bound_expired(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Called at posedge+1; returns at posedge+1 after the ack cycle.
    task automatic host_write(input logic [10:0] addr, input logic [31:0] data,
                              input logic [3:0] be, output int ackc);
        int n = 0;
        wr_req  = 1'b1;
        wr_addr = addr;
        wr_data = data;
        wr_be   = be;
        ackc    = -1;
        while (ackc < 0 && n < 50) begin
            @(negedge clk);
            if (wr_ack) ackc = cyc;
            n++;
        end
        if (ackc < 0) bound_expired("wr_ack");
        else $display("WR   addr=%0d data=%08h be=%b ack@%0d", addr, data, be, ackc);
        @(posedge clk);
        #1;
        wr_req = 1'b0;
    endtask

    // Called at posedge+1; pushes the expected response on acceptance.
    task automatic lookup(input logic [9:0] idx, input logic [7:0] tag, input logic [47:0] mac,
                          input logic [7:0] port, input logic hit, output int acc);
        exp_t e;
        int n = 0;
        req_valid = 1'b1;
        req_idx   = idx;
        req_tag   = tag;
        acc       = -1;
        while (acc < 0 && n < 50) begin
            @(negedge clk);
            if (req_ready) acc = cyc;
            n++;
        end
        if (acc < 0) begin
            bound_expired("req_ready");
        end else begin
            e.tag = tag; e.mac = mac; e.port = port; e.hit = hit; e.acc = acc;
            exp_q.push_back(e);
            $display("REQ  idx=%0d tag=%02h accepted@%0d", idx, tag, acc);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) bound_expired("response drain");
    endtask

    // Monitor: checks every valid response cycle against the queue head
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (ram_we != 4'd0) check("ram_en during write", {63'd0, ram_en}, 64'd0);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected response: tag=%02h (cycle %0d)", rsp_tag, cyc);
                end else begin
                    e = exp_q[0];
                    if (!prev_valid) check("latency", 64'(cyc - e.acc), 64'd3);
                    check("rsp_tag", {56'd0, rsp_tag}, {56'd0, e.tag});
                    check("rsp_mac", {16'd0, rsp_mac}, {16'd0, e.mac});
                    check("rsp_port", {56'd0, rsp_port}, {56'd0, e.port});
                    check("rsp_hit", {63'd0, rsp_hit}, {63'd0, e.hit});
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        $display("RSP  tag=%02h mac=%012h port=%02h hit=%b @%0d",
                                 rsp_tag, rsp_mac, rsp_port, rsp_hit, cyc);
                    end
                end
                if (req_valid) check("req_ready in RESP", {63'd0, req_ready}, 64'd0);
            end
        end
        prev_valid = rsp_valid && !reset;
    end

    initial begin
        int s, a1, a2, k1, k2, h, dummy, n;
        reset = 1'b1; req_valid = 1'b0; req_idx = '0; req_tag = '0; rsp_ready = 1'b1;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;

        // Reset: requests present during reset must not be served
        @(posedge clk); #1;
        mem_clear = 1'b0;
        req_valid = 1'b1; wr_req = 1'b1; wr_be = 4'hF; wr_addr = 11'd3;
        @(negedge clk);
        check("reset req_ready", {63'd0, req_ready}, 64'd0);
        check("reset ram_we", {60'd0, ram_we}, 64'd0);
        check("reset ram_en", {63'd0, ram_en}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0; wr_req = 1'b0; wr_be = '0; wr_addr = '0;
        @(negedge clk);
        check("idle rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("idle req_ready", {63'd0, req_ready}, 64'd0);
        check("idle wr_ack", {63'd0, wr_ack}, 64'd0);
        check("idle rsp_fields", {rsp_tag, rsp_mac, rsp_port}, 64'd0);
        check("idle rsp_hit", {63'd0, rsp_hit}, 64'd0);
        check("idle ram_addr", {53'd0, ram_addr}, 64'd0);
        check("idle ram_wdata", {32'd0, ram_wdata}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle ram_en/we", {59'd0, ram_en, ram_we}, 64'd0);
        end

        // Write and lookup together: write, lookup, write, lookup
        @(posedge clk); #1;
        s = cyc;
        fork
            begin
                host_write(11'd10, 32'h0011_2233, 4'hF, k1);
                host_write(11'd11, 32'h4455_A501, 4'hF, k2);
            end
            begin
                lookup(10'd5, 8'h11, 48'h0011_2233_0000, 8'h00, 1'b0, a1);
                lookup(10'd5, 8'h3C, 48'h0011_2233_4455, 8'hA5, 1'b1, a2);
            end
        join
        check("arb write1 ack", 64'(k1 - s), 64'd1);
        check("arb lookup1 accept", 64'(a1 - s), 64'd2);
        check("arb write2 ack", 64'(k2 - s), 64'd7);
        check("arb lookup2 accept", 64'(a2 - s), 64'd8);
        drain();

        // Invalid entry: miss port, MAC still returned
        @(posedge clk); #1;
        host_write(11'd14, 32'hDEAD_BEEF, 4'hF, dummy);
        host_write(11'd15, 32'h0102_FFFE, 4'hF, dummy);
        lookup(10'd7, 8'hA7, 48'hDEAD_BEEF_0102, 8'h00, 1'b0, dummy);
        drain();

        // Back-pressure: response held, next request waits
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        lookup(10'd5, 8'h5A, 48'h0011_2233_4455, 8'hA5, 1'b1, dummy);
        req_valid = 1'b1; req_idx = 10'd7; req_tag = 8'hB7;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("req_ready while stalled", {63'd0, req_ready}, 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        h = cyc;
        lookup(10'd7, 8'hB7, 48'hDEAD_BEEF_0102, 8'h00, 1'b0, a1);
        check("accept after release", 64'(a1 - h), 64'd1);
        drain();

        // Partial write: only the port byte of W1 changes
        @(posedge clk); #1;
        host_write(11'd11, 32'hFFFF_FFFF, 4'b0010, dummy);
        lookup(10'd5, 8'h99, 48'h0011_2233_4455, 8'hFF, 1'b1, dummy);
        drain();

        // Last entry: words 2046/2047
        @(posedge clk); #1;
        host_write(11'd2046, 32'hA1B2_C3D4, 4'hF, dummy);
        host_write(11'd2047, 32'hE5F6_8181, 4'hF, dummy);
        lookup(10'd1023, 8'hC3, 48'hA1B2_C3D4_E5F6, 8'h81, 1'b1, dummy);
        drain();

        // Reset during RD1 abandons the lookup
        @(posedge clk); #1;
        req_valid = 1'b1; req_idx = 10'd5; req_tag = 8'hEE;
        n = 0;
        a1 = -1;
        while (a1 < 0 && n < 20) begin
            @(negedge clk);
            if (req_ready) a1 = cyc;
            n++;
        end
        if (a1 < 0) bound_expired("req_ready before reset");
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no rsp after reset", {63'd0, rsp_valid}, 64'd0);
        end

        // Recovery after reset
        @(posedge clk); #1;
        lookup(10'd5, 8'hE1, 48'h0011_2233_4455, 8'hFF, 1'b1, dummy);
        drain();
        check("queue empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
